// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues PC to imem over req/ack, buffers the returned word for ID.
// Redirects flush the buffer; a fetch already in flight is finished and its data discarded (DROP).
module if_fetch_unit #(
    parameter logic [31:0] NOP     = 32'h0000_0000,
    parameter int          TIMEOUT = 16,
    parameter int          CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    output logic        pc_stall_o,
    input  logic        redirect_i,
    input  logic        id_stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ir_valid_o,
    output logic [31:0] ir_o,
    output logic [31:0] ir_pc_o,
    output logic        fetch_err_o
);
    typedef enum logic {S_FETCH, S_DROP} state_e;

    state_e             state_q, state_d;
    logic               ir_valid_q, ir_valid_d;
    logic [31:0]        ir_q, ir_d;
    logic [31:0]        ir_pc_q, ir_pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               fetch_err_q, fetch_err_d;

    logic in_drop, id_blocked, req, ack;

    assign in_drop    = (state_q == S_DROP);
    assign id_blocked = ir_valid_q & id_stall_i;
    // Request is suppressed while reset is held even though the state already reads FETCH.
    assign req        = ~reset_i & (in_drop | ~id_blocked);
    assign ack        = req & imem_ack_i;

    assign imem_req_o  = req;
    assign imem_addr_o = in_drop ? addr_q : pc_i;
    assign pc_stall_o  = ~redirect_i & (in_drop | (req & ~ack) | id_blocked);
    assign ir_valid_o  = ir_valid_q;
    assign ir_o        = ir_q;
    assign ir_pc_o     = ir_pc_q;
    assign fetch_err_o = fetch_err_q;

    always_comb begin
        state_d     = state_q;
        ir_valid_d  = ir_valid_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        addr_d      = addr_q;
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;

        if (state_q == S_DROP) begin
            ir_valid_d = 1'b0;
            if (ack) begin
                state_d = S_FETCH;
            end
        end else begin
            if (req) begin
                addr_d = pc_i;
            end
            if (redirect_i) begin
                ir_valid_d = 1'b0;
                if (req && !ack) begin
                    state_d = S_DROP;
                end
            end else if (ack) begin
                ir_d       = imem_rdata_i;
                ir_pc_d    = pc_i;
                ir_valid_d = 1'b1;
            end else if (ir_valid_q && !id_stall_i) begin
                ir_valid_d = 1'b0;
            end
        end

        if (ack) begin
            wait_cnt_d = '0;
        end else if (req) begin
            if (wait_cnt_q != CNT_W'(TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                fetch_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_FETCH;
            ir_valid_q  <= 1'b0;
            ir_q        <= NOP;
            ir_pc_q     <= '0;
            addr_q      <= '0;
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_valid_q  <= ir_valid_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            addr_q      <= addr_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, then random traffic against a program-order model.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, redirect, id_stall, ack;
    logic [31:0] pc, tgt, rdata;
    logic        pc_stall, req, ir_valid, fetch_err;
    logic [31:0] addr, ir, ir_pc;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk_i(clk), .reset_i(reset), .pc_i(pc), .pc_stall_o(pc_stall),
        .redirect_i(redirect), .id_stall_i(id_stall),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
        .ir_valid_o(ir_valid), .ir_o(ir), .ir_pc_o(ir_pc), .fetch_err_o(fetch_err)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // Behavioural PC register: loads target on redirect, holds on stall, else +4.
    task automatic tick();
        logic st;
        #1 st = pc_stall;
        @(posedge clk);
        #1;
        if (!reset) pc = redirect ? tgt : (st ? pc : pc + 32'd4);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", req); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", ir_valid); end
        n_cmp++; if (ir !== 32'h0) begin n_err++; $display("FAIL rst_ir got %h want 0", ir); end
        n_cmp++; if (ir_pc !== 32'h0) begin n_err++; $display("FAIL rst_irpc got %h want 0", ir_pc); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", fetch_err); end
        @(negedge clk);
        reset = 0; pc = 32'h3000; ack = 1; rdata = 32'h3c01_0001;
        #1;
        n_cmp++; if ({req, addr} !== {1'b1, 32'h3000}) begin n_err++; $display("FAIL t1_req got %b/%h want 1/3000", req, addr); end
        n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL t1_stall got %b want 0", pc_stall); end
        tick();
        ack = 0; #1;
        n_cmp++; if ({ir_valid, ir, ir_pc} !== {1'b1, 32'h3c01_0001, 32'h3000})
            begin n_err++; $display("FAIL t1_ir got %b/%h/%h want 1/3c010001/3000", ir_valid, ir, ir_pc); end
    endtask

    task automatic test_wait();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({req, pc_stall, addr} !== {2'b11, 32'h3004})
                begin n_err++; $display("FAIL t2_wait%0d got %b/%b/%h want 1/1/3004", i, req, pc_stall, addr); end
            tick(); #1;
        end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL t2_consumed got %b want 0", ir_valid); end
        ack = 1; rdata = 32'h2000_0004; #1;
        n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL t2_ackstall got %b want 0", pc_stall); end
        tick();
        ack = 0; #1;
        n_cmp++; if ({ir_valid, ir, ir_pc} !== {1'b1, 32'h2000_0004, 32'h3004})
            begin n_err++; $display("FAIL t2_ir got %b/%h/%h want 1/20000004/3004", ir_valid, ir, ir_pc); end
    endtask

    task automatic test_id_stall();
        id_stall = 1; #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({req, pc_stall, ir_valid, ir} !== {3'b011, 32'h2000_0004})
                begin n_err++; $display("FAIL t3_hold%0d got %b/%b/%b/%h want 0/1/1/20000004", i, req, pc_stall, ir_valid, ir); end
            tick(); #1;
        end
        id_stall = 0; #1;
        n_cmp++; if ({req, addr} !== {1'b1, 32'h3008}) begin n_err++; $display("FAIL t3_resume got %b/%h want 1/3008", req, addr); end
        tick();
    endtask

    task automatic test_redirect_drop();
        redirect = 1; tgt = 32'h3100; #1;
        n_cmp++; if ({pc_stall, addr} !== {1'b0, 32'h3008}) begin n_err++; $display("FAIL t4_redir got %b/%h want 0/3008", pc_stall, addr); end
        tick();
        redirect = 0; #1;
        n_cmp++; if ({req, pc_stall, ir_valid, addr} !== {3'b110, 32'h3008})
            begin n_err++; $display("FAIL t4_drop got %b/%b/%b/%h want 1/1/0/3008", req, pc_stall, ir_valid, addr); end
        tick();
        ack = 1; rdata = 32'hdead_beef; #1;
        n_cmp++; if ({pc_stall, addr} !== {1'b1, 32'h3008}) begin n_err++; $display("FAIL t4_dropack got %b/%h want 1/3008", pc_stall, addr); end
        tick();
        ack = 0; #1;
        n_cmp++; if ({ir_valid, req, addr} !== {2'b01, 32'h3100})
            begin n_err++; $display("FAIL t4_after got %b/%b/%h want 0/1/3100", ir_valid, req, addr); end
        ack = 1; rdata = 32'h3100_0000;
        tick();
        ack = 0;
    endtask

    task automatic test_redirect_ack();
        pc = 32'h300c; #1;
        n_cmp++; if ({req, addr} !== {1'b1, 32'h300c}) begin n_err++; $display("FAIL t5_req got %b/%h want 1/300c", req, addr); end
        redirect = 1; tgt = 32'h3200; ack = 1; rdata = 32'h1111_1111; #1;
        n_cmp++; if (pc_stall !== 1'b0) begin n_err++; $display("FAIL t5_stall got %b want 0", pc_stall); end
        tick();
        redirect = 0; ack = 0; #1;
        n_cmp++; if ({ir_valid, req, addr} !== {2'b01, 32'h3200})
            begin n_err++; $display("FAIL t5_after got %b/%b/%h want 0/1/3200", ir_valid, req, addr); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL t6_early%0d got %b want 0", i, fetch_err); end
            tick(); #1;
        end
        n_cmp++; if ({fetch_err, req, addr} !== {2'b11, 32'h3200})
            begin n_err++; $display("FAIL t6_err got %b/%b/%h want 1/1/3200", fetch_err, req, addr); end
        ack = 1; rdata = 32'h3200_0000;
        tick();
        ack = 0; #1;
        n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL t6_sticky got %b want 1", fetch_err); end
        tick(); tick();
        #2 reset = 1; #1;
        n_cmp++; if ({req, ir_valid, fetch_err, pc_stall, ir, ir_pc} !== {4'b0000, 32'h0, 32'h0})
            begin n_err++; $display("FAIL t6_reset got %b/%b/%b/%b/%h/%h want all 0", req, ir_valid, fetch_err, pc_stall, ir, ir_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_next, paddr;
        logic        pend;
        int          lat, ncons;
        pend = 0; ncons = 0; paddr = 0;
        lat = $urandom_range(0, 4);
        @(negedge clk);
        pc = 32'h0001_0000 | ($urandom_range(0, 1023) << 2);
        exp_next = pc;
        reset = 0;
        for (int c = 0; c < 3000; c++) begin
            id_stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'hffff_fffc;
            ack = 0;
            #1;
            if (pend) begin
                n_cmp++; if ({req, addr} !== {1'b1, paddr})
                    begin n_err++; $display("FAIL rnd_hold c%0d got %b/%h want 1/%h", c, req, addr, paddr); end
            end
            if (req) begin
                if (lat == 0) begin ack = 1; rdata = mem(addr); end
                else lat--;
            end
            #1;
            if (ir_valid && !id_stall) begin
                n_cmp++; if (ir_pc !== exp_next) begin n_err++; $display("FAIL rnd_order c%0d got %h want %h", c, ir_pc, exp_next); end
                n_cmp++; if (ir !== mem(ir_pc)) begin n_err++; $display("FAIL rnd_data c%0d got %h want %h", c, ir, mem(ir_pc)); end
                exp_next = ir_pc + 32'd4;
                ncons++;
            end
            if (redirect) exp_next = tgt;
            pend = req && !ack;
            paddr = addr;
            if (ack) lat = $urandom_range(0, 4);
            tick();
        end
        redirect = 0; ack = 0; id_stall = 0; #1;
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rnd_err got %b want 0", fetch_err); end
        n_cmp++; if (ncons < 500) begin n_err++; $display("FAIL rnd_progress got %0d want >=500", ncons); end
    endtask

    initial begin
        reset = 1; pc = 0; redirect = 0; tgt = 0; id_stall = 0; ack = 0; rdata = 0;
        test_reset();
        test_wait();
        test_id_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
